apb_req_master: RTL and testbench

- Bridge from a simple valid/ready request/response port onto a single APB4 (v2.0) master port.
- Sits directly upstream of an APB slave or APB demux; drives paddr/pprot/psel/penable/pwrite/pwdata/pstrb and consumes pready/prdata/pslverr.
- One outstanding transfer at a time; the request fields are registered so the APB outputs are glitch-free and stable.

---
 rtl/apb_req_master_if.sv | 43 ++++
 rtl/apb_req_master.sv | 124 ++++++++++++
 tb/tb_apb_req_master.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_master_if.sv
// rtl/apb_req_master_if.sv - request/response port and APB4 master bus bundle
interface apb_req_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = (DATA_WIDTH + 7) / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_write;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [STRB_WIDTH-1:0] req_strb;
    logic [2:0]            req_prot;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_slverr;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [2:0]            pprot;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [STRB_WIDTH-1:0] pstrb;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
        input  rsp_ready, pready, prdata, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_slverr,
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
        output rsp_ready, pready, prdata, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_slverr,
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb
    );
endinterface

// File: rtl/apb_req_master.sv
// rtl/apb_req_master.sv - valid/ready request to APB4 master bridge, one transfer in flight
// Optional ACCESS-phase timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_req_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    apb_req_master_if.master  bus
);
    localparam int STRB_WIDTH = (DATA_WIDTH + 7) / 8;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state_q;
    logic                  req_ready_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [2:0]            pprot_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [STRB_WIDTH-1:0] pstrb_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_slverr_q;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             limit_hit;
    // The cycle being sampled is the TIMEOUT_CYCLES-th ACCESS cycle.
    assign limit_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pprot_q      <= '0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        paddr_q     <= bus.req_addr;
                        pwrite_q    <= bus.req_write;
                        pwdata_q    <= bus.req_wdata;
                        pprot_q     <= bus.req_prot;
                        pstrb_q     <= bus.req_write ? bus.req_strb : '0;
                        req_ready_q <= 1'b0;
                        psel_q      <= 1'b1;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    cnt_q     <= '0;
`endif
                end
                ACCESS: begin
                    if (bus.pready) begin
                        psel_q       <= 1'b0;
                        penable_q    <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        rsp_slverr_q <= bus.pslverr;
                        rsp_rdata_q  <= pwrite_q ? '0 : bus.prdata;
                        state_q      <= RESP;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (limit_hit) begin
                        psel_q       <= 1'b0;
                        penable_q    <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        rsp_slverr_q <= 1'b1;
                        rsp_rdata_q  <= '0;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.psel       = psel_q;
    assign bus.penable    = penable_q;
    assign bus.pwrite     = pwrite_q;
    assign bus.paddr      = paddr_q;
    assign bus.pprot      = pprot_q;
    assign bus.pwdata     = pwdata_q;
    assign bus.pstrb      = pstrb_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_slverr = rsp_slverr_q;
endmodule

// File: tb/tb_apb_req_master.sv
// tb/tb_apb_req_master.sv - randomized self-checking bench for apb_req_master
module tb_apb_req_master;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    typedef struct packed { logic [31:0] rdata; logic err; } rsp_t;
    rsp_t sb[$];

    apb_req_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_req_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Control view: {req_ready, psel, penable, rsp_valid}
    function automatic logic [3:0] ctrl();
        return {bus.req_ready, bus.psel, bus.penable, bus.rsp_valid};
    endfunction

    function automatic logic [71:0] fields();
        return {bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb, bus.pprot};
    endfunction

    task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot, input int waits,
                           input logic [31:0] rd, input logic err, input int rsp_delay,
                           input bit hold_next);
        logic [71:0] exp_f;
        rsp_t        exp_r;
        exp_f = {addr, wr, wdata, (wr ? strb : 4'h0), prot};
        sb.push_back('{rdata: (wr ? 32'h0 : rd), err: err});
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_addr = addr; bus.req_write = wr;
        bus.req_wdata = wdata; bus.req_strb = strb; bus.req_prot = prot;
        bus.pready = 1'b0; bus.rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl() !== 4'b1000) begin failures++; $display("FAIL accept_ctrl got=%b exp=1000", ctrl()); end
        @(posedge clk); #1;
        bus.req_valid = hold_next;
        bus.req_addr = $urandom; bus.req_wdata = $urandom; bus.req_write = 1'($urandom);
        bus.req_strb = 4'($urandom); bus.req_prot = 3'($urandom);
        bus.pready = 1'b1; bus.prdata = $urandom; bus.pslverr = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl() !== 4'b0100) begin failures++; $display("FAIL setup_ctrl got=%b exp=0100", ctrl()); end
        checks++;
        if (fields() !== exp_f) begin failures++; $display("FAIL setup_fields got=%h exp=%h", fields(), exp_f); end
        for (int w = 0; w <= waits; w++) begin
            @(posedge clk); #1;
            bus.pready  = (w == waits);
            bus.prdata  = (w == waits) ? rd : $urandom;
            bus.pslverr = (w == waits) ? err : 1'($urandom);
            @(negedge clk);
            checks++;
            if (ctrl() !== 4'b0110) begin failures++; $display("FAIL access_ctrl w=%0d got=%b exp=0110", w, ctrl()); end
            checks++;
            if (fields() !== exp_f) begin failures++; $display("FAIL access_fields w=%0d got=%h exp=%h", w, fields(), exp_f); end
        end
        exp_r = sb.pop_front();
        for (int d = 0; d <= rsp_delay; d++) begin
            @(posedge clk); #1;
            bus.pready = 1'($urandom); bus.prdata = $urandom; bus.pslverr = 1'($urandom);
            bus.rsp_ready = (d == rsp_delay);
            @(negedge clk);
            checks++;
            if (ctrl() !== 4'b0001) begin failures++; $display("FAIL resp_ctrl d=%0d got=%b exp=0001", d, ctrl()); end
            checks++;
            if ({bus.rsp_rdata, bus.rsp_slverr} !== exp_r) begin
                failures++;
                $display("FAIL resp_data d=%0d got=%h/%b exp=%h/%b", d, bus.rsp_rdata, bus.rsp_slverr, exp_r.rdata, exp_r.err);
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.req_valid = 1'b0; bus.rsp_ready = 1'($urandom); bus.pready = 1'($urandom);
            @(negedge clk);
            checks++;
            if (ctrl() !== 4'b1000) begin failures++; $display("FAIL idle_ctrl got=%b exp=1000", ctrl()); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ctrl() !== 4'b1000) begin failures++; $display("FAIL reset_ctrl got=%b exp=1000", ctrl()); end
        checks++;
        if ({fields(), bus.rsp_rdata, bus.rsp_slverr} !== 105'h0) begin
            failures++; $display("FAIL reset_data got=%h exp=0", {fields(), bus.rsp_rdata, bus.rsp_slverr});
        end
        rst = 1'b0;
    endtask

    task automatic test_read_zero_wait();
        do_xfer(32'h100, 1'b0, 32'h0, 4'hF, 3'h0, 0, 32'hDEADBEEF, 1'b0, 0, 1'b0);
    endtask

    task automatic test_write_waits();
        do_xfer(32'h20, 1'b1, 32'h12345678, 4'hF, 3'h2, 3, 32'hFFFF0000, 1'b0, 0, 1'b0);
    endtask

    task automatic test_read_err();
        do_xfer(32'h44, 1'b0, 32'hA5A5A5A5, 4'hF, 3'h5, 1, 32'h0BADF00D, 1'b1, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_xfer(32'h300, 1'b1, 32'h11112222, 4'h3, 3'h1, 0, 32'h0, 1'b0, 5, 1'b1);
        do_xfer(32'h304, 1'b0, 32'h0, 4'hC, 3'h6, 0, 32'h33334444, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_addr = 32'h500; bus.req_write = 1'b0;
        bus.pready = 1'b0; bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl() !== 4'b0110) begin failures++; $display("FAIL rstmid_access got=%b exp=0110", ctrl()); end
        @(posedge clk); #1;
        rst = 1'b0; bus.pready = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl() !== 4'b1000) begin failures++; $display("FAIL rstmid_after got=%b exp=1000", ctrl()); end
        bus.pready = 1'b0;
        idle_cycles(2);
        do_xfer(32'h504, 1'b0, 32'h0, 4'h0, 3'h0, 2, 32'h600DCAFE, 1'b0, 0, 1'b0);
    endtask

    task automatic test_stall();
        int n = 0;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_addr = 32'h700; bus.req_write = 1'b0;
        bus.pready = 1'b0; bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            bus.pready = 1'b0; bus.prdata = 32'h12121212;
            @(negedge clk);
            if (bus.penable) n++; else break;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        checks++;
        if (n !== TO) begin failures++; $display("FAIL timeout_cycles got=%0d exp=%0d", n, TO); end
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                bus.pready = (k == 2); bus.prdata = 32'hCAFEF00D; bus.pslverr = 1'b0;
                bus.rsp_ready = (k == 3);
                @(negedge clk);
            end
            checks++;
            if (ctrl() !== 4'b0001) begin failures++; $display("FAIL timeout_ctrl k=%0d got=%b exp=0001", k, ctrl()); end
            checks++;
            if ({bus.rsp_rdata, bus.rsp_slverr} !== {32'h0, 1'b1}) begin
                failures++; $display("FAIL timeout_rsp k=%0d got=%h/%b exp=0/1", k, bus.rsp_rdata, bus.rsp_slverr);
            end
        end
`else
        checks++;
        if (n !== 20) begin failures++; $display("FAIL stall_cycles got=%0d exp=20", n); end
        @(posedge clk); #1;
        bus.pready = 1'b1; bus.prdata = 32'h5A5A0001; bus.pslverr = 1'b0;
        @(posedge clk); #1;
        bus.pready = 1'b0; bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({ctrl(), bus.rsp_rdata, bus.rsp_slverr} !== {4'b0001, 32'h5A5A0001, 1'b0}) begin
            failures++; $display("FAIL stall_rsp got=%b/%h/%b exp=0001/5a5a0001/0", ctrl(), bus.rsp_rdata, bus.rsp_slverr);
        end
`endif
        @(posedge clk); #1;
        bus.pready = 1'b0; bus.rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl() !== 4'b1000) begin failures++; $display("FAIL stall_idle got=%b exp=1000", ctrl()); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_xfer($urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
                    int'($urandom_range(0, TO - 1)), $urandom, 1'($urandom),
                    int'($urandom_range(0, 2)), 1'b0);
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 2)));
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_write = 1'b0; bus.req_wdata = '0;
        bus.req_strb = '0; bus.req_prot = '0; bus.rsp_ready = 1'b0;
        bus.pready = 1'b0; bus.prdata = '0; bus.pslverr = 1'b0;
        test_reset();
        test_read_zero_wait();
        test_write_waits();
        test_read_err();
        test_back_to_back();
        test_reset_mid();
        test_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
